// File: rtl/riscv_types.sv
// Shared FP scheduler types: the unit select enum, default unit latencies
// and the writeback reservation slot record.
package riscv_types;

    localparam int FP_ADDR_W = 5;
    localparam int LAT_FADD  = 4;
    localparam int LAT_FMUL  = 3;
    localparam int LAT_R4    = 8;
    localparam int LAT_MISC  = 1;
    localparam int MAX_LAT   = 8;

    typedef enum logic [1:0] {
        FP_FADD = 2'd0,
        FP_FMUL = 2'd1,
        FP_R4   = 2'd2,
        FP_MISC = 2'd3
    } fp_unit_e;

    typedef struct packed {
        logic                 valid;
        fp_unit_e             unit;
        logic [FP_ADDR_W-1:0] rd;
        logic                 fp_wr;
    } fp_wb_slot_t;

endpackage

// File: rtl/fp_wb_slot_table.sv
// Writeback reservation table: shifts one slot toward writeback per enabled
// cycle and inserts a newly issued op at its retire distance.
module fp_wb_slot_table
    import riscv_types::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          flush,
    input  logic                          i_ins,
    input  logic [$clog2(DEPTH)-1:0]      i_ins_idx,
    input  fp_wb_slot_t                   i_ins_slot,
    output fp_wb_slot_t [DEPTH-1:0]       o_slots
);

    fp_wb_slot_t [DEPTH-1:0] r_slots;
    fp_wb_slot_t [DEPTH-1:0] w_shift;
    fp_wb_slot_t [DEPTH-1:0] w_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_shift
            if (gi == DEPTH - 1) begin : g_top
                assign w_shift[gi] = '0;
            end else begin : g_mid
                assign w_shift[gi] = r_slots[gi+1];
            end
        end
    endgenerate

    // The insert target was checked free (pre-shift slot[L]) before grant.
    always_comb begin
        w_next = w_shift;
        if (i_ins) begin
            w_next[i_ins_idx] = i_ins_slot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slots <= '0;
        end else if (flush) begin
            r_slots <= '0;
        end else if (en) begin
            r_slots <= w_next;
        end
    end

    assign o_slots = r_slots;

endmodule

// File: rtl/fp_issue_scheduler.sv
// FP issue scheduler: writeback-slot reservation plus RAW/WAW interlock.
// Define FP_SCHED_PERF_EN to build the stall performance counters.
module fp_issue_scheduler #(
    parameter int ADDR_W   = 5,
    parameter int LAT_FADD = riscv_types::LAT_FADD,
    parameter int LAT_FMUL = riscv_types::LAT_FMUL,
    parameter int LAT_R4   = riscv_types::LAT_R4,
    parameter int LAT_MISC = riscv_types::LAT_MISC,
    parameter int MAX_LAT  = riscv_types::MAX_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic              req_valid,
    input  logic [1:0]        req_unit,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic              req_fp_wr,
    input  logic [ADDR_W-1:0] req_rs1,
    input  logic [ADDR_W-1:0] req_rs2,
    input  logic [ADDR_W-1:0] req_rs3,
    input  logic [2:0]        req_rs_used,
    output logic              grant,
    output logic              stall,
    output logic [1:0]        stall_cause,
    output logic              wb_valid,
    output logic [1:0]        wb_unit,
    output logic [ADDR_W-1:0] wb_rd,
    output logic              wb_fp_wr,
    output logic [31:0]       fp_pending,
    output logic [31:0]       perf_wb_stall_cnt,
    output logic [31:0]       perf_haz_stall_cnt
);
    import riscv_types::*;

    localparam int IDX_W = $clog2(MAX_LAT);

    fp_wb_slot_t [MAX_LAT-1:0] w_slots;
    fp_wb_slot_t               w_ins_slot;
    logic [IDX_W:0]            w_lat;
    logic [IDX_W-1:0]          w_ins_idx;
    logic                      w_wb_conf;
    logic                      w_raw;
    logic                      w_waw;
    logic                      w_grant;
    logic                      w_stall;
    logic [1:0]                w_cause;
    logic [31:0]               w_pending;
    logic [FP_ADDR_W-1:0]      w_rd;
    logic [FP_ADDR_W-1:0]      w_rs1;
    logic [FP_ADDR_W-1:0]      w_rs2;
    logic [FP_ADDR_W-1:0]      w_rs3;

    assign w_rd  = FP_ADDR_W'(req_rd);
    assign w_rs1 = FP_ADDR_W'(req_rs1);
    assign w_rs2 = FP_ADDR_W'(req_rs2);
    assign w_rs3 = FP_ADDR_W'(req_rs3);

    always_comb begin
        case (req_unit)
            2'd0:    w_lat = (IDX_W+1)'(LAT_FADD);
            2'd1:    w_lat = (IDX_W+1)'(LAT_FMUL);
            2'd2:    w_lat = (IDX_W+1)'(LAT_R4);
            default: w_lat = (IDX_W+1)'(LAT_MISC);
        endcase
    end

    // slot[0] counts as a hazard: results are not forwarded from the wb port.
    always_comb begin
        w_wb_conf = 1'b0;
        w_raw     = 1'b0;
        w_waw     = 1'b0;
        w_pending = '0;
        for (int i = 0; i < MAX_LAT; i++) begin
            if (w_slots[i].valid && (i == int'(w_lat))) begin
                w_wb_conf = 1'b1;
            end
            if (w_slots[i].valid && w_slots[i].fp_wr) begin
                w_pending[w_slots[i].rd] = 1'b1;
                if ((req_rs_used[0] && (w_slots[i].rd == w_rs1)) ||
                    (req_rs_used[1] && (w_slots[i].rd == w_rs2)) ||
                    (req_rs_used[2] && (w_slots[i].rd == w_rs3))) begin
                    w_raw = 1'b1;
                end
                if (req_fp_wr && (w_slots[i].rd == w_rd)) begin
                    w_waw = 1'b1;
                end
            end
        end
    end

    assign w_grant = req_valid & en & ~flush & ~rst & ~(w_wb_conf | w_raw | w_waw);
    assign w_stall = req_valid & ~w_grant & ~flush & ~rst;

    always_comb begin
        w_cause = 2'd0;
        if (w_stall) begin
            if (w_raw) begin
                w_cause = 2'd2;
            end else if (w_waw) begin
                w_cause = 2'd3;
            end else if (w_wb_conf) begin
                w_cause = 2'd1;
            end
        end
    end

    assign w_ins_idx  = IDX_W'(w_lat - 1'b1);
    assign w_ins_slot = '{valid: 1'b1, unit: fp_unit_e'(req_unit), rd: w_rd, fp_wr: req_fp_wr};

    fp_wb_slot_table #(
        .DEPTH (MAX_LAT)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .flush      (flush),
        .i_ins      (w_grant),
        .i_ins_idx  (w_ins_idx),
        .i_ins_slot (w_ins_slot),
        .o_slots    (w_slots)
    );

    assign grant       = w_grant;
    assign stall       = w_stall;
    assign stall_cause = w_cause;
    assign wb_valid    = w_slots[0].valid;
    assign wb_unit     = w_slots[0].unit;
    assign wb_rd       = ADDR_W'(w_slots[0].rd);
    assign wb_fp_wr    = w_slots[0].fp_wr;
    assign fp_pending  = w_pending;

`ifdef FP_SCHED_PERF_EN
    logic [31:0] r_wb_cnt;
    logic [31:0] r_haz_cnt;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_cnt  <= '0;
            r_haz_cnt <= '0;
        end else if (en && w_stall) begin
            if ((w_cause == 2'd1) && (r_wb_cnt != 32'hFFFF_FFFF)) begin
                r_wb_cnt <= r_wb_cnt + 32'd1;
            end
            if (((w_cause == 2'd2) || (w_cause == 2'd3)) && (r_haz_cnt != 32'hFFFF_FFFF)) begin
                r_haz_cnt <= r_haz_cnt + 32'd1;
            end
        end
    end

    assign perf_wb_stall_cnt  = r_wb_cnt;
    assign perf_haz_stall_cnt = r_haz_cnt;
`else
    assign perf_wb_stall_cnt  = 32'd0;
    assign perf_haz_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fp_issue_scheduler.sv
// Self-checking bench for fp_issue_scheduler: directed scenarios plus a
// randomized run against an in-flight op list reference model.
module tb_fp_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        flush;
    logic        req_valid;
    logic [1:0]  req_unit;
    logic [4:0]  req_rd;
    logic        req_fp_wr;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [4:0]  req_rs3;
    logic [2:0]  req_rs_used;
    logic        grant;
    logic        stall;
    logic [1:0]  stall_cause;
    logic        wb_valid;
    logic [1:0]  wb_unit;
    logic [4:0]  wb_rd;
    logic        wb_fp_wr;
    logic [31:0] fp_pending;
    logic [31:0] perf_wb_stall_cnt;
    logic [31:0] perf_haz_stall_cnt;

    int checks = 0;
    int errors = 0;

    fp_issue_scheduler dut (
        .clk                (clk),
        .rst                (rst),
        .en                 (en),
        .flush              (flush),
        .req_valid          (req_valid),
        .req_unit           (req_unit),
        .req_rd             (req_rd),
        .req_fp_wr          (req_fp_wr),
        .req_rs1            (req_rs1),
        .req_rs2            (req_rs2),
        .req_rs3            (req_rs3),
        .req_rs_used        (req_rs_used),
        .grant              (grant),
        .stall              (stall),
        .stall_cause        (stall_cause),
        .wb_valid           (wb_valid),
        .wb_unit            (wb_unit),
        .wb_rd              (wb_rd),
        .wb_fp_wr           (wb_fp_wr),
        .fp_pending         (fp_pending),
        .perf_wb_stall_cnt  (perf_wb_stall_cnt),
        .perf_haz_stall_cnt (perf_haz_stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: each in-flight op knows how many cycles remain until it retires.
    typedef struct {
        int unit;
        int rd;
        bit fp_wr;
        int rem;
    } op_t;

    op_t         q[$];
    bit          m_grant, m_stall, m_wbv, m_wbfp;
    int          m_cause, m_wbu, m_wbrd;
    logic [31:0] m_pend;
    int          m_wbcnt = 0;
    int          m_hazcnt = 0;

    function automatic int lat(input int u);
        case (u)
            0: return 4;
            1: return 3;
            2: return 8;
            default: return 1;
        endcase
    endfunction

    task automatic model_eval();
        int L;
        bit raw, waw, wbc;
        L = lat(int'(req_unit));
        raw = 0; waw = 0; wbc = 0;
        m_wbv = 0; m_wbu = 0; m_wbrd = 0; m_wbfp = 0; m_pend = '0;
        foreach (q[k]) begin
            if (q[k].rem == L) wbc = 1;
            if (q[k].rem == 0) begin
                m_wbv = 1; m_wbu = q[k].unit; m_wbrd = q[k].rd; m_wbfp = q[k].fp_wr;
            end
            if (q[k].fp_wr) begin
                m_pend[q[k].rd] = 1'b1;
                if ((req_rs_used[0] && q[k].rd == int'(req_rs1)) ||
                    (req_rs_used[1] && q[k].rd == int'(req_rs2)) ||
                    (req_rs_used[2] && q[k].rd == int'(req_rs3))) raw = 1;
                if (req_fp_wr && q[k].rd == int'(req_rd)) waw = 1;
            end
        end
        m_grant = req_valid && en && !flush && !(raw || waw || wbc);
        m_stall = req_valid && !m_grant && !flush;
        m_cause = !m_stall ? 0 : raw ? 2 : waw ? 3 : wbc ? 1 : 0;
    endtask

    task automatic model_advance();
        if (en && m_stall) begin
            if (m_cause == 1) m_wbcnt++;
            if (m_cause >= 2) m_hazcnt++;
        end
        if (flush) begin
            q.delete();
        end else if (en) begin
            for (int k = q.size() - 1; k >= 0; k--) begin
                if (q[k].rem == 0) q.delete(k);
                else q[k].rem--;
            end
            if (m_grant) q.push_back('{int'(req_unit), int'(req_rd), req_fp_wr, lat(int'(req_unit)) - 1});
        end
    endtask

    task automatic drive(input bit v, input int u, input int rd, input bit fpw,
                         input int rs1, input int rs2, input int rs3, input int used);
        req_valid   = v;
        req_unit    = 2'(u);
        req_rd      = 5'(rd);
        req_fp_wr   = fpw;
        req_rs1     = 5'(rs1);
        req_rs2     = 5'(rs2);
        req_rs3     = 5'(rs3);
        req_rs_used = 3'(used);
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        en = 1'b1;
        flush = 1'b0;
        repeat (10) begin
            settle();
            advance();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b1;
        flush = 1'b0;
        drive(1, 1, 3, 1, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({grant, stall, stall_cause} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctl: got grant=%0b stall=%0b cause=%0d, want 0 0 0", grant, stall, stall_cause);
        end
        checks++;
        if ({wb_valid, wb_unit, wb_rd, wb_fp_wr} !== 9'b0 || fp_pending !== 32'h0) begin
            errors++;
            $display("FAIL reset_wb: got wbv=%0b u=%0d rd=%0d fp=%0b pend=%h, want all 0", wb_valid, wb_unit, wb_rd, wb_fp_wr, fp_pending);
        end
        checks++;
        if (perf_wb_stall_cnt !== 32'd0 || perf_haz_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf: got %0d %0d, want 0 0", perf_wb_stall_cnt, perf_haz_stall_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        q.delete();
        m_wbcnt = 0;
        m_hazcnt = 0;
    endtask

    task automatic test_fmul_latency();
        for (int c = 0; c < 6; c++) begin
            if (c == 0) drive(1, 1, 3, 1, 0, 0, 0, 0);
            else drive(0, 0, 0, 0, 0, 0, 0, 0);
            settle();
            if (c == 0) begin
                checks++;
                if (grant !== 1'b1) begin
                    errors++;
                    $display("FAIL fmul_grant: got %0b, want 1", grant);
                end
            end
            if (c >= 1 && c <= 3) begin
                checks++;
                if (fp_pending[3] !== 1'b1) begin
                    errors++;
                    $display("FAIL fmul_pending c%0d: got %h, want bit3 set", c, fp_pending);
                end
            end
            checks++;
            if (wb_valid !== (c == 3) || (c == 3 && (wb_unit !== 2'd1 || wb_rd !== 5'd3))) begin
                errors++;
                $display("FAIL fmul_wb c%0d: got wbv=%0b u=%0d rd=%0d, want wbv=%0b u=1 rd=3", c, wb_valid, wb_unit, wb_rd, c == 3);
            end
            advance();
        end
        drain();
    endtask

    task automatic test_wb_conflict();
        bit done = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) drive(1, 0, 1, 1, 0, 0, 0, 0);
            else if (!done) drive(1, 1, 2, 1, 0, 0, 0, 0);
            else drive(0, 0, 0, 0, 0, 0, 0, 0);
            settle();
            if (c == 1) begin
                checks++;
                if ({grant, stall, stall_cause} !== 4'b0101) begin
                    errors++;
                    $display("FAIL wbconf_stall: got grant=%0b stall=%0b cause=%0d, want 0 1 1", grant, stall, stall_cause);
                end
            end
            if (c == 2) begin
                checks++;
                if (grant !== 1'b1) begin
                    errors++;
                    $display("FAIL wbconf_grant: got %0b, want 1", grant);
                end
            end
            checks++;
            if (wb_valid !== (c == 4 || c == 5) ||
                (c == 4 && (wb_unit !== 2'd0 || wb_rd !== 5'd1)) ||
                (c == 5 && (wb_unit !== 2'd1 || wb_rd !== 5'd2))) begin
                errors++;
                $display("FAIL wbconf_wb c%0d: got wbv=%0b u=%0d rd=%0d", c, wb_valid, wb_unit, wb_rd);
            end
            if (c >= 1 && grant === 1'b1) done = 1;
            advance();
        end
        drain();
    endtask

    task automatic test_raw();
        bit done = 0;
        for (int c = 0; c < 15; c++) begin
            if (c == 0) drive(1, 2, 5, 1, 0, 0, 0, 0);
            else if (!done) drive(1, 0, 9, 1, 5, 0, 0, 1);
            else drive(0, 0, 0, 0, 0, 0, 0, 0);
            settle();
            if (c >= 1 && c <= 8) begin
                checks++;
                if ({stall, stall_cause, grant} !== 4'b1100) begin
                    errors++;
                    $display("FAIL raw_stall c%0d: got stall=%0b cause=%0d grant=%0b, want 1 2 0", c, stall, stall_cause, grant);
                end
            end
            if (c == 9) begin
                checks++;
                if (grant !== 1'b1) begin
                    errors++;
                    $display("FAIL raw_grant: got %0b, want 1", grant);
                end
            end
            if (c == 8) begin
                checks++;
                if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_unit !== 2'd2) begin
                    errors++;
                    $display("FAIL raw_wb: got wbv=%0b rd=%0d u=%0d, want 1 5 2", wb_valid, wb_rd, wb_unit);
                end
            end
            if (c >= 1 && grant === 1'b1) done = 1;
            advance();
        end
        drain();
    endtask

    task automatic test_waw();
        bit done = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) drive(1, 0, 7, 1, 0, 0, 0, 0);
            else if (!done) drive(1, 3, 7, 1, 0, 0, 0, 0);
            else drive(0, 0, 0, 0, 0, 0, 0, 0);
            settle();
            if (c >= 1 && c <= 4) begin
                checks++;
                if ({stall, stall_cause, grant} !== 4'b1110) begin
                    errors++;
                    $display("FAIL waw_stall c%0d: got stall=%0b cause=%0d grant=%0b, want 1 3 0", c, stall, stall_cause, grant);
                end
            end
            if (c == 5) begin
                checks++;
                if (grant !== 1'b1) begin
                    errors++;
                    $display("FAIL waw_grant: got %0b, want 1", grant);
                end
            end
            if (c >= 1 && grant === 1'b1) done = 1;
            advance();
        end
        drain();
    endtask

    task automatic test_flush();
        for (int c = 0; c < 13; c++) begin
            flush = (c == 3);
            case (c)
                0: drive(1, 2, 10, 1, 0, 0, 0, 0);
                1: drive(1, 0, 11, 1, 0, 0, 0, 0);
                2: drive(1, 3, 12, 1, 0, 0, 0, 0);
                3: drive(1, 0, 13, 1, 0, 0, 0, 0);
                default: drive(0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            settle();
            if (c <= 2) begin
                checks++;
                if (grant !== 1'b1) begin
                    errors++;
                    $display("FAIL flush_setup c%0d: got grant=%0b, want 1", c, grant);
                end
            end
            if (c == 3) begin
                checks++;
                if ({grant, stall, stall_cause} !== 4'b0 || fp_pending !== 32'h0000_1C00) begin
                    errors++;
                    $display("FAIL flush_cycle: got grant=%0b stall=%0b cause=%0d pend=%h, want 0 0 0 00001c00", grant, stall, stall_cause, fp_pending);
                end
            end
            if (c >= 4) begin
                checks++;
                if (wb_valid !== 1'b0 || fp_pending !== 32'h0) begin
                    errors++;
                    $display("FAIL flush_after c%0d: got wbv=%0b pend=%h, want 0 0", c, wb_valid, fp_pending);
                end
            end
            advance();
        end
        flush = 1'b0;
        drain();
    endtask

    task automatic test_en_freeze();
        bit done = 0;
        logic [31:0] haz0, wb0;
        for (int c = 0; c < 17; c++) begin
            en = !(c >= 1 && c <= 5);
            if (c == 0) drive(1, 2, 20, 1, 0, 0, 0, 0);
            else if (!done) drive(1, 0, 21, 1, 20, 0, 0, 1);
            else drive(0, 0, 0, 0, 0, 0, 0, 0);
            settle();
            if (c == 0) begin
                haz0 = perf_haz_stall_cnt;
                wb0 = perf_wb_stall_cnt;
            end
            checks++;
            if ({grant, stall, stall_cause, wb_valid, wb_unit, wb_rd, wb_fp_wr, fp_pending} !==
                {m_grant, m_stall, 2'(m_cause), m_wbv, 2'(m_wbu), 5'(m_wbrd), m_wbfp, m_pend}) begin
                errors++;
                $display("FAIL freeze_model c%0d: got g=%0b s=%0b c=%0d wbv=%0b rd=%0d pend=%h, want g=%0b s=%0b c=%0d wbv=%0b rd=%0d pend=%h",
                         c, grant, stall, stall_cause, wb_valid, wb_rd, fp_pending, m_grant, m_stall, m_cause, m_wbv, m_wbrd, m_pend);
            end
            if (c >= 1 && c <= 5) begin
                checks++;
                if ({grant, stall, stall_cause} !== 4'b0110) begin
                    errors++;
                    $display("FAIL freeze_hold c%0d: got grant=%0b stall=%0b cause=%0d, want 0 1 2", c, grant, stall, stall_cause);
                end
            end
            checks++;
            if (wb_valid !== (c == 13) || (c == 13 && wb_rd !== 5'd20)) begin
                errors++;
                $display("FAIL freeze_wb c%0d: got wbv=%0b rd=%0d, want wbv=%0b rd=20", c, wb_valid, wb_rd, c == 13);
            end
            if (c == 14) begin
                checks++;
                if (grant !== 1'b1) begin
                    errors++;
                    $display("FAIL freeze_grant: got %0b, want 1", grant);
                end
            end
            if (c >= 1 && grant === 1'b1) done = 1;
            advance();
        end
        @(negedge clk);
        checks++;
`ifdef FP_SCHED_PERF_EN
        if (perf_haz_stall_cnt - haz0 !== 32'd8 || perf_wb_stall_cnt - wb0 !== 32'd0) begin
            errors++;
            $display("FAIL freeze_perf: got haz+%0d wb+%0d, want haz+8 wb+0", perf_haz_stall_cnt - haz0, perf_wb_stall_cnt - wb0);
        end
`else
        if (perf_haz_stall_cnt !== 32'd0 || perf_wb_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL freeze_perf: got haz=%0d wb=%0d, want 0 0", perf_haz_stall_cnt, perf_wb_stall_cnt);
        end
`endif
        drain();
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            case (c)
                0: drive(1, 2, 1, 1, 0, 0, 0, 0);
                1: drive(1, 0, 2, 1, 0, 0, 0, 0);
                default: drive(1, 1, 3, 1, 0, 0, 0, 0);
            endcase
            settle();
            advance();
        end
        drive(1, 3, 4, 1, 1, 2, 3, 7);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({grant, stall, wb_valid} !== 3'b0 || fp_pending !== 32'h0 ||
            perf_wb_stall_cnt !== 32'd0 || perf_haz_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid: got grant=%0b stall=%0b wbv=%0b pend=%h perf=%0d/%0d, want all 0",
                     grant, stall, wb_valid, fp_pending, perf_wb_stall_cnt, perf_haz_stall_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        m_wbcnt = 0;
        m_hazcnt = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 9; c++) begin
            settle();
            checks++;
            if (wb_valid !== 1'b0 || fp_pending !== 32'h0) begin
                errors++;
                $display("FAIL rst_after c%0d: got wbv=%0b pend=%h, want 0 0", c, wb_valid, fp_pending);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            en = ($urandom_range(0, 7) != 0);
            flush = ($urandom_range(0, 31) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 7),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7));
            settle();
            checks++;
            if ({grant, stall, stall_cause, wb_valid, wb_unit, wb_rd, wb_fp_wr, fp_pending} !==
                {m_grant, m_stall, 2'(m_cause), m_wbv, 2'(m_wbu), 5'(m_wbrd), m_wbfp, m_pend}) begin
                errors++;
                $display("FAIL rand c%0d: got g=%0b s=%0b c=%0d wbv=%0b u=%0d rd=%0d fp=%0b pend=%h, want g=%0b s=%0b c=%0d wbv=%0b u=%0d rd=%0d fp=%0b pend=%h",
                         c, grant, stall, stall_cause, wb_valid, wb_unit, wb_rd, wb_fp_wr, fp_pending,
                         m_grant, m_stall, m_cause, m_wbv, m_wbu, m_wbrd, m_wbfp, m_pend);
            end
            advance();
        end
        flush = 1'b0;
        en = 1'b1;
        @(negedge clk);
        checks++;
`ifdef FP_SCHED_PERF_EN
        if (perf_wb_stall_cnt !== 32'(m_wbcnt) || perf_haz_stall_cnt !== 32'(m_hazcnt)) begin
            errors++;
            $display("FAIL rand_perf: got wb=%0d haz=%0d, want wb=%0d haz=%0d", perf_wb_stall_cnt, perf_haz_stall_cnt, m_wbcnt, m_hazcnt);
        end
`else
        if (perf_wb_stall_cnt !== 32'd0 || perf_haz_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rand_perf: got wb=%0d haz=%0d, want 0 0", perf_wb_stall_cnt, perf_haz_stall_cnt);
        end
`endif
        drain();
    endtask

    initial begin
        test_reset();
        test_fmul_latency();
        test_wb_conflict();
        test_raw();
        test_waw();
        test_flush();
        test_en_freeze();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
